// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the program ROM address and hands instructions to the decoder.
// Define FETCH_PREFETCH_EN to insert a 2-entry prefetch FIFO in front of instr_out.
module fetch_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] code_address,
  input  logic [15:0] instruction,
  output logic [15:0] instr_out,
  output logic [11:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump_valid,
  input  logic [11:0] jump_addr,
  input  logic        halt,
  output logic        halted
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HALT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic        can_push;
  logic        fetch;
  logic        flush;
  logic        pop;
  logic        slot_valid;

  // Jump outranks halt and the handshake; halt outranks new fetches.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fetch   = 1'b0;
    flush   = 1'b0;
    if (jump_valid) begin
      pc_d    = jump_addr;
      flush   = 1'b1;
      state_d = halt ? HALT : RUN;
    end else if (halt) begin
      state_d = HALT;
    end else if (can_push) begin
      fetch   = 1'b1;
      pc_d    = pc_q + 12'd1;
      state_d = RUN;
    end else begin
      state_d = STALL;
    end
  end

  assign pop          = slot_valid & instr_ready & ~jump_valid;
  assign code_address = pc_q;
  assign halted       = (state_q == HALT) & ~slot_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_PREFETCH_EN
  logic [1:0]  count_q, count_d, cnt_a;
  logic [15:0] e0_instr_q, e0_instr_d, e1_instr_q, e1_instr_d;
  logic [11:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;

  assign slot_valid = (count_q != 2'd0);
  assign can_push   = (count_q != 2'd2) | instr_ready;

  // Pop shifts entry 1 forward, then the new fetch lands in the first free entry.
  always_comb begin
    cnt_a      = count_q - {1'b0, pop};
    e0_instr_d = pop ? e1_instr_q : e0_instr_q;
    e0_pc_d    = pop ? e1_pc_q : e0_pc_q;
    e1_instr_d = e1_instr_q;
    e1_pc_d    = e1_pc_q;
    count_d    = cnt_a + {1'b0, fetch};
    if (flush) begin
      count_d = 2'd0;
    end else if (fetch) begin
      if (cnt_a == 2'd0) begin
        e0_instr_d = instruction;
        e0_pc_d    = pc_q;
      end else begin
        e1_instr_d = instruction;
        e1_pc_d    = pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      e0_instr_q <= 16'h0000;
      e0_pc_q    <= 12'h000;
      e1_instr_q <= 16'h0000;
      e1_pc_q    <= 12'h000;
    end else begin
      count_q    <= count_d;
      e0_instr_q <= e0_instr_d;
      e0_pc_q    <= e0_pc_d;
      e1_instr_q <= e1_instr_d;
      e1_pc_q    <= e1_pc_d;
    end
  end

  assign instr_out   = e0_instr_q;
  assign instr_pc    = e0_pc_q;
  assign instr_valid = slot_valid;
`else
  logic [15:0] instr_out_q, instr_out_d;
  logic [11:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;

  assign slot_valid = instr_valid_q;
  assign can_push   = ~instr_valid_q | instr_ready;

  always_comb begin
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    if (flush) begin
      instr_valid_d = 1'b0;
    end else if (fetch) begin
      instr_out_d   = instruction;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
    end else if (pop) begin
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out_q   <= 16'h0000;
      instr_pc_q    <= 12'h000;
      instr_valid_q <= 1'b0;
    end else begin
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
`endif

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h000, the first code address fetched after reset.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port code_address, output, 12, the program ROM address (PC).
REQ-005 SHALL have port instruction, input, 16, the program ROM data, combinationally valid in the same cycle as code_address.
REQ-006 SHALL have port instr_out, output, 16, the instruction presented to the decoder.
REQ-007 SHALL have port instr_pc, output, 12, the address from which instr_out was fetched.
REQ-008 SHALL have port instr_valid, output, 1, meaning instr_out holds a valid instruction.
REQ-009 SHALL have port instr_ready, input, 1, meaning the decoder accepts instr_out this cycle.
REQ-010 SHALL have port jump_valid, input, 1, a one-cycle redirect request.
REQ-011 SHALL have port jump_addr, input, 12, the redirect target.
REQ-012 SHALL have port halt, input, 1, the stop-fetch request (level).
REQ-013 SHALL have port halted, output, 1, meaning the sequencer is in HALT with its output slot empty.

Function
REQ-014 SHALL implement states RUN, STALL and HALT, encoded in a registered state variable.
REQ-015 SHALL, in RUN with the output slot empty or being consumed (instr_valid & instr_ready), latch instruction and code_address into instr_out/instr_pc, set instr_valid, and increment the PC by 1, all at the clock edge.
REQ-016 SHALL enter STALL when instr_valid=1 and instr_ready=0, hold the PC, instr_out and instr_pc unchanged, and return to RUN on the cycle instr_ready=1.
REQ-017 SHALL wrap the PC from 12'hFFF to 12'h000 with no error indication.
REQ-018 SHALL, on jump_valid=1 in any state, load the PC with jump_addr, clear instr_valid (flushing the held instruction) and enter RUN, unless halt=1, in which case it enters HALT; code_address SHALL equal jump_addr in the following cycle.
REQ-019 SHALL give jump_valid priority over instr_ready: an instruction held while jump_valid=1 SHALL NOT be delivered, even if instr_ready=1.
REQ-020 SHALL, on halt=1 without a jump, stop PC increment and new fetches, let any held instruction drain through the handshake, and then assert halted.
REQ-021 SHALL hold the PC in HALT and resume fetching from it in RUN on the first cycle halt=0.
REQ-022 SHALL deliver the first instruction with instr_valid=1 one clock edge after rst_n deasserts, from address RESET_PC.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force the PC and code_address to RESET_PC, instr_out to 16'h0000, instr_pc to 12'h000, instr_valid to 0, halted to 0, the state to RUN, and both prefetch entries to empty.
REQ-024 SHALL, on reset asserted mid-operation, discard any held or prefetched instruction without delivering it.

Configuration
REQ-025 SHALL, when FETCH_PREFETCH_EN is defined, place a 2-entry FIFO between the ROM and instr_out. Fetching SHALL continue while the FIFO is not full. STALL SHALL be entered only when the FIFO is full and instr_ready=0. instr_pc SHALL travel with each entry. A jump SHALL flush both entries.
REQ-026 SHALL, when FETCH_PREFETCH_EN is undefined, use the single output register only, with behaviour exactly as REQ-015 to REQ-021.

Verification
REQ-027 SHALL cover free run: reset release with instr_ready=1 -> instr_pc sequence 000,001,002,003 on consecutive cycles and instr_out equal to ROM[instr_pc].
REQ-028 SHALL cover back-pressure: instr_ready=0 for 3 cycles at instr_pc=002 -> instr_out and instr_pc stable for those cycles, and 003 delivered on the cycle after instr_ready returns to 1 (non-prefetch build).
REQ-029 SHALL cover redirect: jump_valid=1 with jump_addr=12'h003 while instr_pc=001 is held and instr_ready=1 -> 001 not accepted, instr_valid=0 for one cycle, then instr_pc=003.
REQ-030 SHALL cover wrap: jump to 12'hFFE with instr_ready=1 -> instr_pc FFE, FFF, 000.
REQ-031 SHALL cover halt with jump: halt=1 and jump_valid=1 with jump_addr=12'h004 -> halted=1, code_address=004 held; halt=0 -> next delivered instr_pc=004.
REQ-032 SHALL cover reset mid-stall: rst_n pulsed low while instr_valid=1 and instr_ready=0 -> instr_valid=0 immediately and first delivered instr_pc=RESET_PC, in both macro builds.
